// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues reads to a 1-cycle synchronous
// instruction memory, buffers returned words in a 2-entry queue and presents
// the head {inst, pc} to the instruction register. Handles downstream stall and
// branch/jump redirect, squashing wrong-path fetches.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic        out_valid
);

    // Architectural and pipeline state.
    logic [31:0] pc_q, pc_d;
    logic        inflight_q, inflight_d;
    logic [31:0] inflight_pc_q, inflight_pc_d;
    logic        head_q, head_d;
    logic        tail_q, tail_d;
    logic [1:0]  count_q, count_d;

    // Queue storage (data only, qualified by count).
    logic [31:0] q_inst_q [2];
    logic [31:0] q_inst_d [2];
    logic [31:0] q_pc_q   [2];
    logic [31:0] q_pc_d   [2];

    // Per-cycle handshake terms.
    logic        pop;
    logic        push;
    logic [2:0]  credit;
    logic [31:0] target_pc;

    // Output presentation, issue credit check and response capture.
    always_comb begin
        // NOTE: every signal driven here gets a value before any branch, so no latch can be inferred.
        out_valid = 1'b0;
        out_inst  = NOP;
        out_pc    = 32'h0000_0000;
        pop       = 1'b0;
        push      = 1'b0;
        imem_en   = 1'b0;
        imem_addr = pc_q;
        target_pc = redirect_pc & ~32'h0000_0003;

        out_valid = (count_q != 2'd0) & ~redirect & ~reset;
        if (out_valid) begin
            out_inst = q_inst_q[head_q];
            out_pc   = q_pc_q[head_q];
        end
        pop = out_valid & ~stall;

        // Slots already committed (queued + in flight) after this cycle's pop.
        credit  = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
        imem_en = ~reset & ~redirect & (credit < 3'd2);

        // A response arriving during a redirect belongs to the wrong path.
        push = inflight_q & ~redirect & ~reset;
    end

    // Next-state for PC, in-flight tracking, queue pointers and queue contents.
    always_comb begin
        pc_d          = pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;
        q_inst_d      = q_inst_q;
        q_pc_d        = q_pc_q;

        if (redirect) begin
            // Flush everything; the target is fetched next cycle.
            pc_d    = target_pc;
            head_d  = 1'b0;
            tail_d  = 1'b0;
            count_d = 2'd0;
        end else begin
            if (imem_en) begin
                inflight_d    = 1'b1;
                inflight_pc_d = pc_q;
                pc_d          = pc_q + 32'd4;
            end
            if (push) begin
                q_inst_d[tail_q] = imem_rdata;
                q_pc_d[tail_q]   = inflight_pc_q;
                tail_d           = ~tail_q;
            end
            if (pop) begin
                head_d = ~head_q;
            end
            count_d = count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= 32'h0000_0000;
            head_q        <= 1'b0;
            tail_q        <= 1'b0;
            count_q       <= 2'd0;
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
        end
    end

    // Queue data registers.
    always_ff @(posedge clk) begin
        // NOTE: queue data is not reset; count gates validity, so stale contents are never visible.
        q_inst_q <= q_inst_d;
        q_pc_q   <= q_pc_d;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed latency/stall/redirect/wrap/reset
// scenarios followed by randomized stall/redirect/reset traffic. Expected
// output stream per fetch segment is pushed by the stimulus; a negedge monitor
// pops and compares whenever the DUT hands over an instruction.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0000;
    localparam logic [31:0] KEY      = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        out_valid;

    int total = 0;
    int bad   = 0;
    int pops  = 0;
    logic armed = 1'b0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [31:0] next_exp;

    logic        prev_hold = 1'b0;
    logic [31:0] prev_pc;
    logic [31:0] prev_inst;

    fetch_unit #(.RESET_PC(RESET_PC), .NOP(NOP)) dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .imem_en    (imem_en),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .out_inst   (out_inst),
        .out_pc     (out_pc),
        .out_valid  (out_valid)
    );

    always #5 clk = ~clk;

    // Synchronous instruction memory: word = address ^ KEY; junk when not read.
    always @(posedge clk) begin
        if (imem_en) imem_rdata <= imem_addr ^ KEY;
        else         imem_rdata <= $urandom;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: after a restart at address T the stage delivers T, T+4, T+8, ...
    task automatic topup();
        while (exp_q.size() < 16) begin
            exp_q.push_back('{pc: next_exp, inst: next_exp ^ KEY});
            next_exp = next_exp + 32'd4;
        end
    endtask

    task automatic start_seg(input logic [31:0] pc);
        exp_q.delete();
        next_exp = pc;
        topup();
    endtask

    // One clock: drive inputs just after the edge, then settle mid-cycle.
    task automatic cycle(input logic r, input logic s, input logic d, input logic [31:0] dpc);
        @(posedge clk);
        #1;
        reset       = r;
        stall       = s;
        redirect    = d;
        redirect_pc = dpc;
        if (r)      start_seg(RESET_PC);
        else if (d) start_seg(dpc & ~32'h0000_0003);
        topup();
        #3;
    endtask

    // Monitor: scoreboard pops on every handover, plus idle and hold rules.
    always @(negedge clk) begin
        if (armed) begin
            if (reset || redirect) check("valid_low_on_flush", 32'(out_valid), 32'd0);
            if (!out_valid) begin
                check("idle_inst_nop", out_inst, NOP);
                check("idle_pc_zero", out_pc, 32'd0);
            end
            if (prev_hold && !reset && !redirect) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_pc", out_pc, prev_pc);
                check("hold_inst", out_inst, prev_inst);
            end
            if (out_valid && !stall) begin
                check("scoreboard_nonempty", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    check("stream_pc", out_pc, mon_e.pc);
                    check("stream_inst", out_inst, mon_e.inst);
                    pops++;
                end
            end
            prev_hold = out_valid && stall;
            prev_pc   = out_pc;
            prev_inst = out_inst;
        end
    end

    initial begin
        reset       = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        start_seg(RESET_PC);
        @(posedge clk);
        #1;
        armed = 1'b1;
        #3;

        // Reset cycle outputs
        check("rst_imem_en", 32'(imem_en), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_inst", out_inst, NOP);
        check("rst_out_pc", out_pc, 32'd0);
        cycle(1'b1, 1'b0, 1'b0, 32'd0);

        // Latency from reset release
        cycle(1'b0, 1'b0, 1'b0, 32'd0);
        check("lat_en_n", 32'(imem_en), 32'd1);
        check("lat_addr_n", imem_addr, RESET_PC);
        check("lat_valid_n", 32'(out_valid), 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 32'd0);
        check("lat_valid_n1", 32'(out_valid), 32'd0);
        check("lat_addr_n1", imem_addr, RESET_PC + 32'd4);
        cycle(1'b0, 1'b0, 1'b0, 32'd0);
        check("lat_valid_n2", 32'(out_valid), 32'd1);
        check("lat_pc_n2", out_pc, RESET_PC);
        check("lat_inst_n2", out_inst, RESET_PC ^ KEY);

        // Free run: one instruction per cycle
        for (int k = 1; k < 10; k++) begin
            cycle(1'b0, 1'b0, 1'b0, 32'd0);
            check("run_valid", 32'(out_valid), 32'd1);
            check("run_pc", out_pc, RESET_PC + 32'(4 * k));
        end

        // Stall held 5 cycles: output frozen at pc 40, no issue
        for (int k = 0; k < 5; k++) begin
            cycle(1'b0, 1'b1, 1'b0, 32'd0);
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_pc", out_pc, RESET_PC + 32'd40);
            check("stall_en", 32'(imem_en), 32'd0);
        end
        cycle(1'b0, 1'b0, 1'b0, 32'd0);
        check("release_en", 32'(imem_en), 32'd1);
        check("release_pc0", out_pc, RESET_PC + 32'd40);
        for (int k = 1; k < 4; k++) begin
            cycle(1'b0, 1'b0, 1'b0, 32'd0);
            check("release_valid", 32'(out_valid), 32'd1);
            check("release_pc", out_pc, RESET_PC + 32'd40 + 32'(4 * k));
        end

        // Redirect together with stall: redirect wins
        cycle(1'b0, 1'b1, 1'b1, 32'h0000_2002);
        check("rs_valid_r", 32'(out_valid), 32'd0);
        check("rs_en_r", 32'(imem_en), 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 32'd0);
        check("rs_en_r1", 32'(imem_en), 32'd1);
        check("rs_addr_r1", imem_addr, 32'h0000_2000);
        cycle(1'b0, 1'b0, 1'b0, 32'd0);
        check("rs_valid_r2", 32'(out_valid), 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 32'd0);
        check("rs_pc_r3", out_pc, 32'h0000_2000);
        check("rs_inst_r3", out_inst, 32'h0000_2000 ^ KEY);
        cycle(1'b0, 1'b0, 1'b0, 32'd0);
        check("rs_pc_r4", out_pc, 32'h0000_2004);

        // Redirect with a full queue
        cycle(1'b0, 1'b1, 1'b0, 32'd0);
        cycle(1'b0, 1'b1, 1'b0, 32'd0);
        check("full_en", 32'(imem_en), 32'd0);
        cycle(1'b0, 1'b0, 1'b1, 32'h0000_0101);
        check("rd_valid_r", 32'(out_valid), 32'd0);
        check("rd_en_r", 32'(imem_en), 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 32'd0);
        check("rd_en_r1", 32'(imem_en), 32'd1);
        check("rd_addr_r1", imem_addr, 32'h0000_0100);
        check("rd_valid_r1", 32'(out_valid), 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 32'd0);
        check("rd_valid_r2", 32'(out_valid), 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 32'd0);
        check("rd_valid_r3", 32'(out_valid), 32'd1);
        check("rd_pc_r3", out_pc, 32'h0000_0100);
        check("rd_inst_r3", out_inst, 32'h0000_0100 ^ KEY);

        // PC wrap past the top of the address space
        cycle(1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8);
        cycle(1'b0, 1'b0, 1'b0, 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 32'd0);
        check("wrap_pc0", out_pc, 32'hFFFF_FFF8);
        cycle(1'b0, 1'b0, 1'b0, 32'd0);
        check("wrap_pc1", out_pc, 32'hFFFF_FFFC);
        cycle(1'b0, 1'b0, 1'b0, 32'd0);
        check("wrap_pc2", out_pc, 32'h0000_0000);
        check("wrap_inst2", out_inst, 32'h0000_0000 ^ KEY);

        // Reset pulse mid-stream while stalled
        cycle(1'b0, 1'b1, 1'b0, 32'd0);
        cycle(1'b0, 1'b1, 1'b0, 32'd0);
        cycle(1'b1, 1'b1, 1'b0, 32'd0);
        check("mrst_valid", 32'(out_valid), 32'd0);
        check("mrst_en", 32'(imem_en), 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 32'd0);
        check("mrst_valid_n", 32'(out_valid), 32'd0);
        check("mrst_addr_n", imem_addr, RESET_PC);
        cycle(1'b0, 1'b0, 1'b0, 32'd0);
        check("mrst_valid_n1", 32'(out_valid), 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 32'd0);
        check("mrst_valid_n2", 32'(out_valid), 32'd1);
        check("mrst_pc_n2", out_pc, RESET_PC);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 299) == 0,
                  $urandom_range(0, 99) < 35,
                  $urandom_range(0, 99) < 3,
                  $urandom);
        end
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 1'b0, 32'd0);
        check("handovers_seen", 32'(pops > 1000), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
